// File: rtl/nec_ir_pkg.sv
// Shared definitions for the NEC IR receiver.
// Holds the FSM state type, the pulse-width acceptance windows and the
// no-edge timeout limits. All widths are counted in 10 us ticks.
package nec_ir_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StRepMark,
    StDone
  } state_e;

  localparam int unsigned TickUs = 10;

  localparam int unsigned WidthW = 11;

  // Inclusive acceptance windows, in ticks.
  localparam logic [WidthW-1:0] LeadMarkMin  = 11'd800;
  localparam logic [WidthW-1:0] LeadMarkMax  = 11'd1000;
  localparam logic [WidthW-1:0] LeadSpaceMin = 11'd400;
  localparam logic [WidthW-1:0] LeadSpaceMax = 11'd500;
  localparam logic [WidthW-1:0] RepSpaceMin  = 11'd180;
  localparam logic [WidthW-1:0] RepSpaceMax  = 11'd270;
  localparam logic [WidthW-1:0] BitMarkMin   = 11'd40;
  localparam logic [WidthW-1:0] BitMarkMax   = 11'd75;
  localparam logic [WidthW-1:0] Space0Min    = 11'd40;
  localparam logic [WidthW-1:0] Space0Max    = 11'd75;
  localparam logic [WidthW-1:0] Space1Min    = 11'd140;
  localparam logic [WidthW-1:0] Space1Max    = 11'd200;

  // A mark or space this long without an edge aborts the frame.
  localparam logic [WidthW-1:0] MarkTimeout  = 11'd1001;
  localparam logic [WidthW-1:0] SpaceTimeout = 11'd501;

  function automatic logic in_win(input logic [WidthW-1:0] w,
                                  input logic [WidthW-1:0] lo,
                                  input logic [WidthW-1:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

endpackage

// File: rtl/ir_tick_gen.sv
// 10 us tick generator for the NEC IR receiver.
// Ports:
//   clk  - system clock
//   rst  - synchronous reset, active-low
//   tick - one-clk pulse every CLK_FREQ/100_000 clocks
// CLK_FREQ must be at least 100_000 so the divider is >= 1.
module ir_tick_gen #(
  parameter int unsigned CLK_FREQ = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned Div  = CLK_FREQ / 100_000;
  localparam int unsigned CntW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(Div - 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (cnt_q == CntMax) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick = (cnt_q == CntMax);

endmodule

// File: rtl/nec_ir_receiver.sv
// NEC IR frame decoder.
// Synchronizes the raw IR line, measures each mark/space in 10 us ticks and
// walks an FSM through lead, 32 data bits and trailing mark (or a repeat frame).
// Ports:
//   clk      - system clock, all logic on posedge
//   rst      - synchronous reset, active-low
//   ir_i     - raw asynchronous IR receiver output
//   code     - last valid frame, first received bit in code[31]
//   newCode  - one-clk pulse when code is updated
//   repeat_o - one-clk pulse on a valid repeat frame
//   err_o    - one-clk pulse on a timing or command-check violation
//   busy     - high while the FSM is not idle
module nec_ir_receiver
  import nec_ir_pkg::*;
#(
  parameter int unsigned CLK_FREQ      = 100_000_000,
  parameter bit          IR_ACTIVE_LOW = 1'b1,
  parameter bit          CHECK_CMD     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_i,
  output logic [31:0] code,
  output logic        newCode,
  output logic        repeat_o,
  output logic        err_o,
  output logic        busy
);

  // ir_i level that means "no carrier".
  localparam logic IdleLvl = IR_ACTIVE_LOW ? 1'b1 : 1'b0;

  logic              tick;
  logic [1:0]        sync_q;
  logic              mark;
  logic              mark_q;
  logic              edge_det;
  logic              rise;
  logic              fall;
  logic [WidthW-1:0] width_q;
  logic [WidthW-1:0] w;
  logic              timeout;
  logic              chk_ok;
  state_e            state_q;
  logic [31:0]       sr_q;
  logic [5:0]        bit_cnt_q;

  ir_tick_gen #(
    .CLK_FREQ (CLK_FREQ)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {2{IdleLvl}};
      mark_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], ir_i};
      mark_q <= mark;
    end
  end

  assign mark     = sync_q[1] ^ IdleLvl;
  assign edge_det = mark ^ mark_q;
  assign rise     = mark & ~mark_q;
  assign fall     = ~mark & mark_q;

  // Edge beats a coincident tick; saturates so a long idle line is harmless.
  always_ff @(posedge clk) begin
    if (!rst) begin
      width_q <= '0;
    end else if (edge_det) begin
      width_q <= '0;
    end else if (tick && (width_q != {WidthW{1'b1}})) begin
      width_q <= width_q + 1'b1;
    end
  end

  // On an edge the counter still holds the duration that just ended.
  assign w       = width_q;
  assign timeout = mark ? (width_q >= MarkTimeout) : (width_q >= SpaceTimeout);
  assign chk_ok  = !CHECK_CMD || (sr_q[7:0] == ~sr_q[15:8]);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      code      <= '0;
      newCode   <= 1'b0;
      repeat_o  <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      newCode  <= 1'b0;
      repeat_o <= 1'b0;
      err_o    <= 1'b0;
      if ((state_q != StIdle) && (state_q != StDone) && !edge_det && timeout) begin
        err_o   <= 1'b1;
        state_q <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (rise) state_q <= StLeadMark;
          end
          StLeadMark: begin
            if (fall) begin
              if (in_win(w, LeadMarkMin, LeadMarkMax)) begin
                state_q <= StLeadSpace;
              end else begin
                err_o   <= 1'b1;
                state_q <= StIdle;
              end
            end
          end
          StLeadSpace: begin
            if (rise) begin
              if (in_win(w, LeadSpaceMin, LeadSpaceMax)) begin
                bit_cnt_q <= '0;
                state_q   <= StBitMark;
              end else if (in_win(w, RepSpaceMin, RepSpaceMax)) begin
                state_q <= StRepMark;
              end else begin
                err_o   <= 1'b1;
                state_q <= StIdle;
              end
            end
          end
          StBitMark: begin
            if (fall) begin
              if (!in_win(w, BitMarkMin, BitMarkMax)) begin
                err_o   <= 1'b1;
                state_q <= StIdle;
              end else if (bit_cnt_q < 6'd32) begin
                state_q <= StBitSpace;
              end else begin
                // Trailing mark: result is issued here so it lands 3 clk after
                // the ir_i edge; StDone only holds busy for one more cycle.
                if (chk_ok) begin
                  code    <= sr_q;
                  newCode <= 1'b1;
                end else begin
                  err_o <= 1'b1;
                end
                state_q <= StDone;
              end
            end
          end
          StBitSpace: begin
            if (rise) begin
              if (in_win(w, Space0Min, Space0Max)) begin
                sr_q      <= {sr_q[30:0], 1'b0};
                bit_cnt_q <= bit_cnt_q + 6'd1;
                state_q   <= StBitMark;
              end else if (in_win(w, Space1Min, Space1Max)) begin
                sr_q      <= {sr_q[30:0], 1'b1};
                bit_cnt_q <= bit_cnt_q + 6'd1;
                state_q   <= StBitMark;
              end else begin
                err_o   <= 1'b1;
                state_q <= StIdle;
              end
            end
          end
          StRepMark: begin
            if (fall) begin
              if (in_win(w, BitMarkMin, BitMarkMax)) begin
                repeat_o <= 1'b1;
              end else begin
                err_o <= 1'b1;
              end
              state_q <= StIdle;
            end
          end
          StDone: begin
            state_q <= StIdle;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

  assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_nec_ir_receiver.sv
// Directed bench for nec_ir_receiver. Two instances share one IR line: one
// with the command check enabled, one with it disabled. With CLK_FREQ=100_000
// one clock equals one 10 us tick, so durations below are in ticks.
module tb_nec_ir_receiver;

  typedef struct {
    logic [2:0]  kind;  // {newCode, repeat_o, err_o}
    logic [31:0] code;
    longint      due;
  } exp_t;

  localparam logic [2:0] KNone = 3'b000;
  localparam logic [2:0] KNew  = 3'b100;
  localparam logic [2:0] KRep  = 3'b010;
  localparam logic [2:0] KErr  = 3'b001;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ir  = 1'b1;
  logic [31:0] code_a, code_b;
  logic        nc_a, rp_a, er_a, busy_a;
  logic        nc_b, rp_b, er_b, busy_b;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  longint last_cyc = 0;
  exp_t   sb_a[$];
  exp_t   sb_b[$];
  exp_t   e_a, e_b;

  nec_ir_receiver #(
    .CLK_FREQ      (100_000),
    .IR_ACTIVE_LOW (1'b1),
    .CHECK_CMD     (1'b1)
  ) dut_a (
    .clk      (clk),
    .rst      (rst),
    .ir_i     (ir),
    .code     (code_a),
    .newCode  (nc_a),
    .repeat_o (rp_a),
    .err_o    (er_a),
    .busy     (busy_a)
  );

  nec_ir_receiver #(
    .CLK_FREQ      (100_000),
    .IR_ACTIVE_LOW (1'b1),
    .CHECK_CMD     (1'b0)
  ) dut_b (
    .clk      (clk),
    .rst      (rst),
    .ir_i     (ir),
    .code     (code_b),
    .newCode  (nc_b),
    .repeat_o (rp_b),
    .err_o    (er_b),
    .busy     (busy_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard side: every pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (nc_a | rp_a | er_a) begin
      checks++;
      assert (sb_a.size() > 0) else begin
        errors++;
        $error("FAIL a_unexpected pulse=%b code=%h at cyc %0d", {nc_a, rp_a, er_a}, code_a, cyc);
      end
      if (sb_a.size() > 0) begin
        e_a = sb_a.pop_front();
        checks += 3;
        assert ({nc_a, rp_a, er_a} === e_a.kind) else begin
          errors++;
          $error("FAIL a_kind got=%b want=%b", {nc_a, rp_a, er_a}, e_a.kind);
        end
        assert (code_a === e_a.code) else begin
          errors++;
          $error("FAIL a_code got=%h want=%h", code_a, e_a.code);
        end
        assert (cyc === e_a.due) else begin
          errors++;
          $error("FAIL a_latency got=%0d want=%0d", cyc, e_a.due);
        end
      end
    end
    if (nc_b | rp_b | er_b) begin
      checks++;
      assert (sb_b.size() > 0) else begin
        errors++;
        $error("FAIL b_unexpected pulse=%b code=%h at cyc %0d", {nc_b, rp_b, er_b}, code_b, cyc);
      end
      if (sb_b.size() > 0) begin
        e_b = sb_b.pop_front();
        checks += 3;
        assert ({nc_b, rp_b, er_b} === e_b.kind) else begin
          errors++;
          $error("FAIL b_kind got=%b want=%b", {nc_b, rp_b, er_b}, e_b.kind);
        end
        assert (code_b === e_b.code) else begin
          errors++;
          $error("FAIL b_code got=%h want=%h", code_b, e_b.code);
        end
        assert (cyc === e_b.due) else begin
          errors++;
          $error("FAIL b_latency got=%0d want=%0d", cyc, e_b.due);
        end
      end
    end
  end

  function automatic int sc(input int n, input int pct);
    return n * (100 + pct) / 100;
  endfunction

  // Drive a new IR level on the current negedge and remember when.
  task automatic drive(input logic lvl);
    ir = lvl;
    last_cyc = cyc;
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [2:0] ka, input logic [31:0] ca,
                      input logic [2:0] kb, input logic [31:0] cb);
    if (ka != KNone) sb_a.push_back('{ka, ca, last_cyc + 3});
    if (kb != KNone) sb_b.push_back('{kb, cb, last_cyc + 3});
  endtask

  // Sends one frame MSB first (mark = ir low). bad_bit stretches that bit's
  // space to 100 ticks, abort_bit resets mid-space, lead_len overrides the
  // lead mark; the expectation is registered at the edge that should trigger it.
  task automatic send_frame(input logic [31:0] data, input int pct, input int bad_bit,
                            input int abort_bit, input int lead_len,
                            input logic [2:0] ka, input logic [31:0] ca,
                            input logic [2:0] kb, input logic [31:0] cb);
    int bm;
    bm = sc(56, pct);
    drive(1'b0);
    hold((lead_len > 0) ? lead_len : sc(900, pct));
    drive(1'b1);
    if (lead_len > 0) begin
      push(ka, ca, kb, cb);
      hold(1000);
      return;
    end
    hold(sc(450, pct));
    for (int b = 0; b < 32; b++) begin
      drive(1'b0);
      hold(bm);
      drive(1'b1);
      if (b == abort_bit) begin
        hold(30);
        checks += 2;
        assert (busy_a === 1'b1) else begin
          errors++;
          $error("FAIL busy_a_midframe got=%b want=1", busy_a);
        end
        assert (busy_b === 1'b1) else begin
          errors++;
          $error("FAIL busy_b_midframe got=%b want=1", busy_b);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        hold(600);
        return;
      end
      if (b == bad_bit) begin
        hold(100);
        drive(1'b0);
        push(ka, ca, kb, cb);
        hold(bm);
        drive(1'b1);
        hold(1000);
        return;
      end
      hold(data[31-b] ? sc(169, pct) : sc(56, pct));
    end
    drive(1'b0);
    hold(bm);
    drive(1'b1);
    push(ka, ca, kb, cb);
    hold(300);
  endtask

  task automatic send_repeat(input logic [31:0] ca, input logic [31:0] cb);
    drive(1'b0);
    hold(900);
    drive(1'b1);
    hold(225);
    drive(1'b0);
    hold(56);
    drive(1'b1);
    push(KRep, ca, KRep, cb);
    hold(300);
  endtask

  task automatic check_idle(input string tag, input logic [31:0] ca, input logic [31:0] cb);
    checks += 4;
    assert (code_a === ca) else begin
      errors++;
      $error("FAIL %s code_a got=%h want=%h", tag, code_a, ca);
    end
    assert (code_b === cb) else begin
      errors++;
      $error("FAIL %s code_b got=%h want=%h", tag, code_b, cb);
    end
    assert (busy_a === 1'b0) else begin
      errors++;
      $error("FAIL %s busy_a got=%b want=0", tag, busy_a);
    end
    assert (busy_b === 1'b0) else begin
      errors++;
      $error("FAIL %s busy_b got=%b want=0", tag, busy_b);
    end
  endtask

  initial begin
    rst = 1'b0;
    ir  = 1'b1;
    repeat (5) @(negedge clk);
    check_idle("reset", 32'h0, 32'h0);
    checks++;
    assert ({nc_a, rp_a, er_a, nc_b, rp_b, er_b} === 6'b0) else begin
      errors++;
      $error("FAIL reset_pulses got=%b want=000000", {nc_a, rp_a, er_a, nc_b, rp_b, er_b});
    end
    rst = 1'b1;
    hold(50);

    // Nominal frame, then a repeat 40 ms later.
    send_frame(32'h00FF40BF, 0, -1, -1, 0, KNew, 32'h00FF40BF, KNew, 32'h00FF40BF);
    hold(4000);
    send_repeat(32'h00FF40BF, 32'h00FF40BF);
    check_idle("after_repeat", 32'h00FF40BF, 32'h00FF40BF);

    // Command check fails only on the checking instance.
    send_frame(32'h00FF40BE, 0, -1, -1, 0, KErr, 32'h00FF40BF, KNew, 32'h00FF40BE);

    // 1000 us space at bit 10, then a clean frame.
    send_frame(32'h00FFE01F, 0, 10, -1, 0, KErr, 32'h00FF40BF, KErr, 32'h00FF40BE);
    check_idle("after_bad_space", 32'h00FF40BF, 32'h00FF40BE);
    send_frame(32'h00FFE01F, 0, -1, -1, 0, KNew, 32'h00FFE01F, KNew, 32'h00FFE01F);

    // Reset during bit 20 discards everything.
    send_frame(32'h00FF10EF, 0, -1, 20, 0, KNone, 32'h0, KNone, 32'h0);
    check_idle("after_midframe_reset", 32'h0, 32'h0);
    send_frame(32'h00FF10EF, 0, -1, -1, 0, KNew, 32'h00FF10EF, KNew, 32'h00FF10EF);

    // Timing margins and a short lead mark.
    send_frame(32'h00FF609F, 10, -1, -1, 0, KNew, 32'h00FF609F, KNew, 32'h00FF609F);
    send_frame(32'h00FF609F, -10, -1, -1, 0, KNew, 32'h00FF609F, KNew, 32'h00FF609F);
    send_frame(32'h00FF609F, 0, -1, -1, 700, KErr, 32'h00FF609F, KErr, 32'h00FF609F);
    check_idle("final", 32'h00FF609F, 32'h00FF609F);

    // Any expectation still queued is a pulse that never arrived.
    checks += 2;
    assert (sb_a.size() == 0) else begin
      errors++;
      $error("FAIL a_missing_pulses got=%0d want=0", sb_a.size());
    end
    assert (sb_b.size() == 0) else begin
      errors++;
      $error("FAIL b_missing_pulses got=%0d want=0", sb_b.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
